pipe_stage_skid: RTL and testbench

Parametrised pipeline-stage register, the successor to the fixed-field stage registers between Decode, Execute, Memory and Writeback. It carries a DATA_W-bit bundle with a valid/ready handshake and a 2-entry skid buffer, so upstream `in_ready` is a flop and not a combinational path from downstream stall. A synchronous `flush` inserts a bubble. The block is instantiated once per stage boundary, with DATA_W sized to that stage's control-plus-datapath bundle.

---
 rtl/pipe_stage_skid_if.sv | 12 +
 rtl/pipe_stage_skid.sv | 118 +++++++++++
 tb/tb_pipe_stage_skid.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data handshake bundle for one side of a pipeline stage boundary.
// master drives valid/data, slave drives ready.
interface pipe_stage_skid_if #(
    parameter int unsigned DATA_W = 32
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with 2-entry skid buffer, registered in_ready and flush.
// Optional saturating stall/flush counters are enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 hold,
    pipe_stage_skid_if.slave     upstream,
    pipe_stage_skid_if.master    downstream,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     flush_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT             state;
    logic [DATA_W-1:0] mainQ;
    logic [DATA_W-1:0] skidQ;
    logic              inReadyQ;
    logic              acceptC;
    logic              popC;
    logic              validC;

    assign validC  = (state != EMPTY);
    assign acceptC = upstream.valid & inReadyQ;
    assign popC    = validC & downstream.ready & ~hold;

    assign upstream.ready   = inReadyQ;
    assign downstream.valid = validC;
    assign downstream.data  = mainQ;

    // in_ready is loaded with (next state != FULL) so it never depends on this cycle's stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= EMPTY;
            mainQ    <= '0;
            skidQ    <= '0;
            inReadyQ <= 1'b1;
        end else if (flush) begin
            state    <= EMPTY;
            mainQ    <= '0;
            skidQ    <= '0;
            inReadyQ <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    inReadyQ <= 1'b1;
                    if (acceptC) begin
                        mainQ <= upstream.data;
                        state <= ONE;
                    end
                end
                ONE: begin
                    if (acceptC && !popC) begin
                        skidQ    <= upstream.data;
                        state    <= FULL;
                        inReadyQ <= 1'b0;
                    end else if (acceptC && popC) begin
                        mainQ    <= upstream.data;
                        inReadyQ <= 1'b1;
                    end else if (popC) begin
                        state    <= EMPTY;
                        inReadyQ <= 1'b1;
                    end else begin
                        inReadyQ <= 1'b1;
                    end
                end
                FULL: begin
                    if (popC) begin
                        mainQ    <= skidQ;
                        state    <= ONE;
                        inReadyQ <= 1'b1;
                    end else begin
                        inReadyQ <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    inReadyQ <= 1'b1;
                end
            endcase
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stallCntQ;
    logic [CNT_W-1:0] flushCntQ;

    // Saturating counters, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stallCntQ <= '0;
            flushCntQ <= '0;
        end else begin
            if (validC && !popC && !(&stallCntQ)) begin
                stallCntQ <= stallCntQ + CNT_W'(1);
            end
            if (flush && validC && !(&flushCntQ)) begin
                flushCntQ <= flushCntQ + CNT_W'(1);
            end
        end
    end

    assign stall_cnt = stallCntQ;
    assign flush_cnt = flushCntQ;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_pipe_stage_skid;

    localparam int unsigned DW   = 32;
    localparam int unsigned CW   = 4;
    localparam int          CMAX = (1 << CW) - 1;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic          clk;
    logic          rst_n;
    logic          flush;
    logic          hold;
    logic [CW-1:0] stall_cnt;
    logic [CW-1:0] flush_cnt;

    pipe_stage_skid_if #(.DATA_W(DW)) upIf ();
    pipe_stage_skid_if #(.DATA_W(DW)) dnIf ();

    pipe_stage_skid #(.DATA_W(DW), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .hold       (hold),
        .upstream   (upIf),
        .downstream (dnIf),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: FIFO of held bundles (max 2), last presented value, counters
    logic [DW-1:0] mq[$];
    logic [DW-1:0] mLast;
    bit            mReady;
    int            mStall;
    int            mFlush;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            mLast  = '0;
            mReady = 1'b1;
            mStall = 0;
            mFlush = 0;
        end else begin
            bit acc;
            bit pp;
            acc = upIf.valid & mReady;
            pp  = (mq.size() > 0) & dnIf.ready & ~hold;
            if (mq.size() > 0 && !pp && mStall < CMAX) mStall++;
            if (flush && mq.size() > 0 && mFlush < CMAX) mFlush++;
            if (flush) begin
                mq.delete();
                mLast = '0;
            end else begin
                if (pp) void'(mq.pop_front());
                if (acc) mq.push_back(upIf.data);
                if (mq.size() > 0) mLast = mq[0];
            end
            mReady = (mq.size() < 2);
        end
    end

    always @(negedge clk) begin
        chk("out_valid", 64'(dnIf.valid), 64'(mq.size() > 0));
        chk("out_data",  64'(dnIf.data),  64'(mLast));
        chk("in_ready",  64'(upIf.ready), 64'(mReady));
        chk("stall_cnt", 64'(stall_cnt),  PERF ? 64'(mStall) : 64'd0);
        chk("flush_cnt", 64'(flush_cnt),  PERF ? 64'(mFlush) : 64'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] d);
        upIf.valid = 1'b1;
        upIf.data  = d;
        step();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b1;
        flush      = 1'b0;
        hold       = 1'b0;
        upIf.valid = 1'b0;
        upIf.data  = '0;
        dnIf.ready = 1'b1;
        #2;
        reset_dut();
        chk("rst_valid", 64'(dnIf.valid), 64'd0);
        chk("rst_ready", 64'(upIf.ready), 64'd1);
        chk("rst_data",  64'(dnIf.data),  64'd0);
        chk("rst_stall", 64'(stall_cnt),  64'd0);

        // Streaming, one per cycle
        push(32'h11); chk("st_11", 64'(dnIf.data), 64'h11); chk("st_v1", 64'(dnIf.valid), 64'd1);
        push(32'h22); chk("st_22", 64'(dnIf.data), 64'h22);
        push(32'h33); chk("st_33", 64'(dnIf.data), 64'h33);
        upIf.valid = 1'b0;
        step(); chk("st_empty", 64'(dnIf.valid), 64'd0);

        // Backpressure into skid
        dnIf.ready = 1'b0;
        push(32'hA1);
        push(32'hA2); chk("bp_a1", 64'(dnIf.data), 64'hA1); chk("bp_full_rdy", 64'(upIf.ready), 64'd0);
        push(32'hA3); chk("bp_hold_a1", 64'(dnIf.data), 64'hA1);
        dnIf.ready = 1'b1;
        step(); chk("bp_a2", 64'(dnIf.data), 64'hA2); chk("bp_rdy_back", 64'(upIf.ready), 64'd1);
        step(); chk("bp_a3", 64'(dnIf.data), 64'hA3);
        upIf.valid = 1'b0;
        step(); chk("bp_drain", 64'(dnIf.valid), 64'd0);

        // Flush while FULL with a concurrent accept-attempt
        reset_dut();
        dnIf.ready = 1'b0;
        push(32'hB1);
        push(32'hB2);
        upIf.data = 32'hB3;
        flush     = 1'b1;
        step();
        flush = 1'b0; upIf.valid = 1'b0; dnIf.ready = 1'b1;
        chk("fl_valid", 64'(dnIf.valid), 64'd0);
        chk("fl_data",  64'(dnIf.data),  64'd0);
        chk("fl_ready", 64'(upIf.ready), 64'd1);
        chk("fl_cnt",   64'(flush_cnt),  PERF ? 64'd1 : 64'd0);
        step(); chk("fl_no_b3", 64'(dnIf.valid), 64'd0);

        // Hold in ONE, then hold+flush
        reset_dut();
        hold = 1'b1;
        push(32'hD1);
        upIf.valid = 1'b0;
        repeat (4) step();
        chk("hd_data",  64'(dnIf.data), 64'hD1);
        chk("hd_stall", 64'(stall_cnt), PERF ? 64'd4 : 64'd0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("hf_valid", 64'(dnIf.valid), 64'd0);
        chk("hf_cnt",   64'(flush_cnt),  PERF ? 64'd1 : 64'd0);
        hold = 1'b0;

        // Asynchronous reset while FULL
        dnIf.ready = 1'b0;
        push(32'hE1);
        push(32'hE2);
        upIf.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(dnIf.valid), 64'd0);
        chk("ar_ready", 64'(upIf.ready), 64'd1);
        chk("ar_data",  64'(dnIf.data),  64'd0);
        step();
        rst_n = 1'b1;
        dnIf.ready = 1'b1;
        push(32'hC1);
        chk("ar_c1", 64'(dnIf.data), 64'hC1);
        chk("ar_c1v", 64'(dnIf.valid), 64'd1);
        upIf.valid = 1'b0;
        step();

        // Counter saturation
        reset_dut();
        hold = 1'b1;
        push(32'hF1);
        upIf.valid = 1'b0;
        repeat (20) step();
        chk("sat_stall", 64'(stall_cnt), PERF ? 64'd15 : 64'd0);
        hold = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 700 == 699) reset_dut();
            upIf.valid = 1'($urandom_range(0, 1));
            upIf.data  = $urandom;
            dnIf.ready = ($urandom_range(0, 3) != 0);
            hold       = ($urandom_range(0, 5) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            step();
        end
        upIf.valid = 1'b0;
        flush      = 1'b0;
        hold       = 1'b0;
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
